can_rx_fifo_reader: RTL
=======================

// Module: can_rx_fifo_reader
// PURPOSE
//  Read side of the CAN RX FIFO. It pops one 128-bit received message when the FIFO is non-empty,
//  buffers it, then streams it to the host/register interface as WORD_W-bit words over a
//  valid/ready handshake. It sits between the RX FIFO and the host bus slave, opposite the
//  acceptance-filter write path.
// PARAMETERS
//  DATA_W       128  width of one FIFO entry (one CAN message); must be a multiple of WORD_W
//  WORD_W       32   host word width
//  RD_LATENCY   1    cycles from o_rx_r_en to valid i_rx_fifo_r_data (1..4)
//  CNT_W        8    width of delivered-message counter
// PORTS
//  i_sys_clk         in   1        system clock; all logic on rising edge
//  i_reset_n         in   1        synchronous reset, active low
//  i_rx_empty        in   1        RX FIFO empty flag
//  o_rx_r_en         out  1        RX FIFO pop strobe, one cycle per message
//  i_rx_fifo_r_data  in   DATA_W   FIFO read data, valid RD_LATENCY cycles after pop
//  i_flush           in   1        discard the buffered/in-flight message, return to IDLE
//  o_word_valid      out  1        o_word_data holds a valid word
//  i_word_ready      in   1        host accepts the word this cycle
//  o_word_data       out  WORD_W   current word
//  o_word_idx        out  $clog2(DATA_W/WORD_W)  index of current word, 0 = first
//  o_word_last       out  1        current word is the final word of the message
//  o_msg_count       out  CNT_W    messages fully delivered since reset, wraps
//  o_busy            out  1        state != IDLE
// BEHAVIOUR
//  Reset (i_reset_n=0 at an edge): state=IDLE; o_rx_r_en=0, o_word_valid=0, o_word_data=0,
//   o_word_idx=0, o_word_last=0, o_msg_count=0, o_busy=0, buffer=0. Reset mid-message drops it.
//  States: IDLE, WAIT, SEND.
//  IDLE: if !i_rx_empty && !i_flush -> o_rx_r_en=1 for exactly this cycle (combinational from
//   state+empty), latency counter loaded with RD_LATENCY, go WAIT. o_rx_r_en is never 1 while
//   i_rx_empty=1 or in any state other than IDLE.
//  WAIT: counter decrements each cycle; on the cycle i_rx_fifo_r_data is valid (RD_LATENCY cycles
//   after pop), capture it into the buffer, set word index 0, go SEND.
//  SEND: o_word_valid=1. o_word_data = buffer[DATA_W-1-idx*WORD_W -: WORD_W], so word 0 is bits
//   [127:96] (ID/control first). o_word_last=1 iff idx == DATA_W/WORD_W-1.
//   Handshake = o_word_valid && i_word_ready. Data, idx and last are held stable while valid
//   and not ready. On a non-last handshake idx+1. On the last handshake o_msg_count+1
//   (wraps 2^CNT_W-1 -> 0), go IDLE. The next pop happens no earlier than the following cycle,
//   so there is a one-cycle bubble per message.
//  Latency: pop to word 0 valid = RD_LATENCY+1 cycles. Zero-stall message = 1+RD_LATENCY+N cycles
//   (N = DATA_W/WORD_W).
//  i_flush (any state) has priority over every other event: next state IDLE, o_word_valid=0,
//   idx=0, no count increment even if the last handshake coincides; no pop in that cycle.
//   FIFO data still arriving after a flush in WAIT is ignored. The popped entry is lost by design.
//  i_rx_empty is sampled only in IDLE. Empty rising during WAIT/SEND does not matter.
//  Never pops twice for one message. Never issues valid without a captured buffer.
// TESTING
//  1 Reset: hold i_reset_n=0 with i_rx_empty=0 -> o_rx_r_en=0, all outputs 0; release -> pop
//    on the next cycle.
//  2 Single message 0x11112222_33334444_55556666_77778888, ready=1, RD_LATENCY=1 -> words
//    0x11112222,0x33334444,0x55556666,0x77778888; idx 0..3; last only on 4th word; count 0->1.
//  3 Backpressure: ready low 3 cycles on word 1 -> word 1 data/idx held stable; no second pop;
//    sequence completes unchanged.
//  4 Back-to-back: 3 entries queued, ready=1 -> exactly 3 pops, each separated by 6 cycles
//    (RD_LATENCY=1); count=3; no pop after empty.
//  5 Flush: assert i_flush in WAIT, then in SEND at idx=2 -> IDLE next cycle, valid=0, count
//    unchanged; the next message starts at idx 0. Flush coinciding with the last handshake ->
//    count unchanged.
//  6 Wrap and latency: CNT_W=8, deliver 256 messages -> count=0. Rerun with RD_LATENCY=3 ->
//    word 0 valid 4 cycles after the pop.

Source files
------------

// File: rtl/can_rx_fifo_reader.sv
// Read side of the CAN RX FIFO: pops one message, buffers it, and streams it
// to the host as WORD_W-bit words over a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no message held; pops the FIFO when it is non-empty
// WAIT  | pop issued; counting down the FIFO read latency
// SEND  | buffer captured; presenting words, word 0 = most significant
module can_rx_fifo_reader #(
    parameter int DATA_W     = 128,
    parameter int WORD_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 8,
    localparam int N_WORDS   = DATA_W / WORD_W,
    localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              i_sys_clk,
    input  logic              i_reset_n,
    input  logic              i_rx_empty,
    output logic              o_rx_r_en,
    input  logic [DATA_W-1:0] i_rx_fifo_r_data,
    input  logic              i_flush,
    output logic              o_word_valid,
    input  logic              i_word_ready,
    output logic [WORD_W-1:0] o_word_data,
    output logic [IDX_W-1:0]  o_word_idx,
    output logic              o_word_last,
    output logic [CNT_W-1:0]  o_msg_count,
    output logic              o_busy
);

    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pop;
    logic                idx_is_last;
    logic [WORD_W-1:0]   word_sel;

    assign idx_is_last = (idx_q == IDX_W'(N_WORDS - 1));

    // State, latency timer, word index, buffer and message counter registers.
    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; flush overrides every other event, including the last handshake.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (i_flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_rx_empty) begin
                        pop     = 1'b1;
                        lat_d   = LAT_W'(RD_LATENCY);
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_q == LAT_W'(1)) begin
                        buf_d   = i_rx_fifo_r_data;
                        idx_d   = '0;
                        state_d = ST_SEND;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (i_word_ready) begin
                        if (idx_is_last) begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            idx_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Word mux: word 0 is the top slice of the buffer (ID/control first).
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word_sel = buf_q[DATA_W-1-i*WORD_W -: WORD_W];
            end
        end
    end

    // Pop is held off while reset is asserted so the FIFO is not drained during reset.
    assign o_rx_r_en    = pop && i_reset_n;
    assign o_word_valid = (state_q == ST_SEND);
    assign o_word_data  = word_sel;
    assign o_word_idx   = idx_q;
    assign o_word_last  = (state_q == ST_SEND) && idx_is_last;
    assign o_msg_count  = cnt_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
